// File: rtl/mux_16_1_arbiter.sv
// mux_16_1_arbiter
//   Round-robin arbiter sharing one 16:1 1-bit select mux between 16
//   requesters. S feeds the mux select directly. GNT is a one-hot grant.
//   A grant is held until the owner releases it (DONE, or its REQ bit drops).
//   On release the grant hands off in the same edge to the next requester
//   in rotating order.
//
//   Optional build macro: ARB_TIMEOUT_EN
//     Limits one owner to MAX_HOLD consecutive BUSY cycles. An owner that
//     overstays is forcibly released, and TIMEOUT pulses for one cycle.
//     Without the macro, TIMEOUT is tied to 0.
//
// Ports
//   CLK      in   1   clock, rising edge
//   RST      in   1   asynchronous active-high reset
//   REQ      in  16   request vector, bit i = requester i (mux input Xi)
//   DONE     in   1   current owner releases this cycle (ignored when idle)
//   S        out  4   registered mux select, current or last owner
//   GNT      out 16   registered one-hot grant, zero when idle
//   VALID    out  1   registered, high while a grant is held
//   TIMEOUT  out  1   registered one-cycle pulse on forced release
module mux_16_1_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] REQ,
  input  logic        DONE,
  output logic [3:0]  S,
  output logic [15:0] GNT,
  output logic        VALID,
  output logic        TIMEOUT
);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e      state_q, state_d;
  logic [3:0]  ptr_q, ptr_d;
  logic [3:0]  s_q, s_d;
  logic [15:0] gnt_q, gnt_d;
  logic        valid_q, valid_d;

  logic [15:0] arb_vec;
  logic [3:0]  arb_base;
  logic [4:0]  pick;     // {found, index}
  logic        rel_norm;
  logic        forced;

  // First set bit of vec, searching upward from base and wrapping 15->0.
  // The loop runs downward so the lowest offset from base is written last.
  function automatic logic [4:0] rr_pick(input logic [15:0] vec,
                                         input logic [3:0]  base);
    logic [4:0] r;
    logic [3:0] idx;
    r = '0;
    for (int i = 15; i >= 0; i--) begin
      idx = base + 4'(i);
      if (vec[idx]) r = {1'b1, idx};
    end
    return r;
  endfunction

`ifdef ARB_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       to_q, to_d;
  // Forced on the edge that would complete the MAX_HOLD-th held cycle.
  assign forced = (state_q == BUSY) && !rel_norm &&
                  (cnt_q == 8'(MAX_HOLD - 1));
`else
  logic unused_max_hold;
  assign unused_max_hold = ^8'(MAX_HOLD);
  assign forced          = 1'b0;
`endif

  assign rel_norm = DONE | ~REQ[s_q];

  // In BUSY the current owner is masked out, and the search starts just past it.
  assign arb_vec  = (state_q == BUSY) ? (REQ & ~gnt_q) : REQ;
  assign arb_base = (state_q == BUSY) ? (s_q + 4'd1)   : ptr_q;
  assign pick     = rr_pick(arb_vec, arb_base);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    s_d     = s_q;
    gnt_d   = gnt_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    to_d    = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (pick[4]) begin
          s_d     = pick[3:0];
          gnt_d   = 16'd1 << pick[3:0];
          state_d = BUSY;
`ifdef ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      BUSY: begin
        if (rel_norm || forced) begin
          ptr_d = s_q + 4'd1;
`ifdef ARB_TIMEOUT_EN
          cnt_d = '0;
          to_d  = forced;
`endif
          if (pick[4]) begin
            s_d   = pick[3:0];
            gnt_d = 16'd1 << pick[3:0];
          end else begin
            gnt_d   = '0;
            state_d = IDLE;
          end
        end else begin
`ifdef ARB_TIMEOUT_EN
          cnt_d = cnt_q + 8'd1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    valid_d = (state_d == BUSY);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      s_q     <= '0;
      gnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      s_q     <= s_d;
      gnt_q   <= gnt_d;
      valid_q <= valid_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q <= '0;
      to_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      to_q  <= to_d;
    end
  end
  assign TIMEOUT = to_q;
`else
  assign TIMEOUT = 1'b0;
`endif

  assign S     = s_q;
  assign GNT   = gnt_q;
  assign VALID = valid_q;

endmodule

// File: tb/tb_mux_16_1_arbiter.sv
module tb_mux_16_1_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic [15:0] REQ;
  logic        DONE;
  logic [3:0]  S;
  logic [15:0] GNT;
  logic        VALID;
  logic        TIMEOUT;

  int errors = 0;
  int checks = 0;

  mux_16_1_arbiter #(.MAX_HOLD(4)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .DONE(DONE),
    .S(S), .GNT(GNT), .VALID(VALID), .TIMEOUT(TIMEOUT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [15:0] req;
    logic        done;
    logic [3:0]  s;
    logic [15:0] gnt;
    logic        valid;
  } vec_t;

  vec_t tbl[19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One rising edge, then settle away from it.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Mux model driven by the arbiter: X = GNT, OUT = X[S].
  task automatic chk_mux(input string name);
    logic [15:0] x;
    x = GNT;
    if (VALID) chk({name, "_mux_out"}, 32'(x[S]), 32'd1);
  endtask

  task automatic chk_all(input string name, input logic [3:0] s,
                         input logic [15:0] g, input logic v);
    chk({name, "_S"}, 32'(S), 32'(s));
    chk({name, "_GNT"}, 32'(GNT), 32'(g));
    chk({name, "_VALID"}, 32'(VALID), 32'(v));
    chk({name, "_TIMEOUT"}, 32'(TIMEOUT), 32'd0);
  endtask

  initial begin
    // req, done -> expected s, gnt, valid (PTR tracked by hand in comments)
    tbl[0]  = '{16'h0010, 1'b0, 4'd4,  16'h0010, 1'b1}; // idle, ptr0 -> 4
    tbl[1]  = '{16'h0010, 1'b0, 4'd4,  16'h0010, 1'b1}; // hold
    tbl[2]  = '{16'h0030, 1'b0, 4'd4,  16'h0010, 1'b1}; // non-owner change ignored
    tbl[3]  = '{16'h0030, 1'b1, 4'd5,  16'h0020, 1'b1}; // DONE, handoff to 5
    tbl[4]  = '{16'h0000, 1'b0, 4'd5,  16'h0000, 1'b0}; // req drop, idle, ptr6
    tbl[5]  = '{16'h0000, 1'b1, 4'd5,  16'h0000, 1'b0}; // DONE ignored in idle
    tbl[6]  = '{16'h0021, 1'b0, 4'd0,  16'h0001, 1'b1}; // from ptr6 wraps to 0
    tbl[7]  = '{16'h0008, 1'b1, 4'd3,  16'h0008, 1'b1}; // handoff to 3
    tbl[8]  = '{16'h0108, 1'b0, 4'd3,  16'h0008, 1'b1}; // hold owner 3
    tbl[9]  = '{16'h0100, 1'b0, 4'd8,  16'h0100, 1'b1}; // owner drops -> 8
    tbl[10] = '{16'h0000, 1'b1, 4'd8,  16'h0000, 1'b0}; // idle, S parked, ptr9
    tbl[11] = '{16'h8000, 1'b0, 4'd15, 16'h8000, 1'b1}; // grant 15
    tbl[12] = '{16'h0000, 1'b1, 4'd15, 16'h0000, 1'b0}; // idle, ptr0
    tbl[13] = '{16'h8001, 1'b0, 4'd0,  16'h0001, 1'b1}; // fairness: 0 not 15
    tbl[14] = '{16'h0000, 1'b1, 4'd0,  16'h0000, 1'b0}; // idle, ptr1
    tbl[15] = '{16'h2000, 1'b0, 4'd13, 16'h2000, 1'b1}; // grant 13
    tbl[16] = '{16'h0000, 1'b1, 4'd13, 16'h0000, 1'b0}; // idle, ptr14
    tbl[17] = '{16'h8001, 1'b0, 4'd15, 16'h8000, 1'b1}; // ptr14 -> 15
    tbl[18] = '{16'h0000, 1'b1, 4'd15, 16'h0000, 1'b0}; // idle, ptr0

    RST = 1'b1; REQ = '0; DONE = 1'b0;
    #12;
    chk_all("reset", 4'd0, 16'h0000, 1'b0);
    RST = 1'b0;

    for (int i = 0; i < 19; i++) begin
      REQ  = tbl[i].req;
      DONE = tbl[i].done;
      tick();
      chk_all($sformatf("vec%0d", i), tbl[i].s, tbl[i].gnt, tbl[i].valid);
      chk_mux($sformatf("vec%0d", i));
    end

    // Rotation: all requesting, DONE each cycle -> 0,1,...,15,0,1 back-to-back.
    REQ = 16'hFFFF; DONE = 1'b0;
    tick();
    chk_all("rot0", 4'd0, 16'h0001, 1'b1);
    DONE = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      logic [3:0] e;
      e = 4'(k);
      tick();
      chk_all($sformatf("rot%0d", k), e, 16'd1 << e, 1'b1);
      chk_mux($sformatf("rot%0d", k));
    end

    // Asynchronous reset mid-grant: outputs clear without a clock edge.
    #2 RST = 1'b1;
    #1;
    chk_all("rst_mid", 4'd0, 16'h0000, 1'b0);
    #3 RST = 1'b0;
    REQ = 16'h0006; DONE = 1'b0;
    tick();
    chk_all("post_rst_ptr0", 4'd1, 16'h0002, 1'b1);
    REQ = 16'h0000; DONE = 1'b1;
    tick();
    chk_all("post_rst_idle", 4'd1, 16'h0000, 1'b0); // ptr now 2

    // Hold limit: owner 0 never releases.
    REQ = 16'h0003; DONE = 1'b0;
    tick();
    chk_all("hold_grant", 4'd0, 16'h0001, 1'b1);
`ifdef ARB_TIMEOUT_EN
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("to_hold%0d_S", k), 32'(S), 32'd0);
      chk($sformatf("to_hold%0d_TO", k), 32'(TIMEOUT), 32'd0);
    end
    tick();
    chk("to_fire_S", 32'(S), 32'd1);
    chk("to_fire_GNT", 32'(GNT), 32'h0002);
    chk("to_fire_TO", 32'(TIMEOUT), 32'd1);
    tick();
    chk("to_after_S", 32'(S), 32'd1);
    chk("to_after_TO", 32'(TIMEOUT), 32'd0);
`else
    for (int k = 0; k < 20; k++) begin
      tick();
      chk_all($sformatf("nohold%0d", k), 4'd0, 16'h0001, 1'b1);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
